// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared definitions for the instruction-fetch interface: responder
//            state encoding, instruction width and HALT opcode detection.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    RESP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [10:0] HALT_PREFIX = 11'h7FF;
  localparam int          HALT_MSB    = 31;
  localparam int          HALT_LSB    = 21;
  localparam int          INSTR_BYTES = 4;

  // True when the instruction carries the HALT opcode prefix.
  function automatic logic is_halt(input logic [31:0] instr);
    return instr[HALT_MSB:HALT_LSB] == HALT_PREFIX;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_responder_if
// Purpose  : Fetch request/response channel between the fetch unit (master)
//            and the instruction memory responder (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface imem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_err;
  logic        rsp_halt;

  modport master (
    output req_valid, req_pc, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_err, rsp_halt
  );

  modport slave (
    input  req_valid, req_pc, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_err, rsp_halt
  );
endinterface
`default_nettype wire

// File: rtl/imem_byte_ram.sv
`default_nettype none
// ============================================================================
// Module   : imem_byte_ram
// Purpose  : Byte-wide instruction storage with one combinational read port
//            and one synchronous write port. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module imem_byte_ram #(
  parameter int DEPTH_BYTES = 4096,
  parameter int AW          = 12
) (
  input  wire logic          clk,
  input  wire logic [AW-1:0] raddr,
  output logic      [7:0]    rdata,
  input  wire logic          we,
  input  wire logic [AW-1:0] waddr,
  input  wire logic [7:0]    wdata
);

  logic [7:0] r_mem [DEPTH_BYTES];

  // Preload / byte write; the caller guarantees no overlap with reads.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : imem_responder
// Purpose  : Serves 64-bit-PC fetch requests from a byte-addressed memory,
//            assembling each little-endian word one byte per cycle, flagging
//            misaligned/out-of-range PCs and the HALT opcode.
// Revision : 1.0 - initial release
// ============================================================================
module imem_responder
  import fetch_pkg::*;
#(
  parameter int DEPTH_BYTES = 4096,
  parameter int LD_AW       = 12
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  imem_responder_if.slave       bus,
  output logic                  halted,
  input  wire logic             ld_en,
  input  wire logic [LD_AW-1:0] ld_addr,
  input  wire logic [7:0]       ld_data
);

  localparam logic [63:0] c_max_pc   = 64'(DEPTH_BYTES - INSTR_BYTES);
  localparam logic [1:0]  c_last_cnt = 2'(INSTR_BYTES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [LD_AW-1:0] r_pc;
  logic [1:0]       r_cnt;
  logic [31:0]      r_instr;
  logic             r_err;
  logic             r_halted;

  logic             w_req_ready;
  logic             w_accept;
  logic             w_pc_bad;
  logic             w_halt_word;
  logic [7:0]       w_rdata;
  logic             w_we;

  // Handshake and classification of the incoming PC (full 64-bit range check).
  assign w_req_ready = rst_n && (r_state == IDLE) && !ld_en && !r_halted;
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_pc_bad    = (bus.req_pc[1:0] != 2'b00) || (bus.req_pc > c_max_pc);
  assign w_halt_word = is_halt(r_instr) && !r_err;

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_instr = r_instr;
  assign bus.rsp_err   = r_err;
  assign bus.rsp_halt  = (r_state == RESP) && w_halt_word;
  assign halted        = r_halted;

  // Loads only land while the read path is idle.
  assign w_we = ld_en && ((r_state == IDLE) || (r_state == HALTED));

  imem_byte_ram #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .AW          (LD_AW)
  ) u_ram (
    .clk   (clk),
    .raddr (r_pc + LD_AW'(r_cnt)),
    .rdata (w_rdata),
    .we    (w_we),
    .waddr (ld_addr),
    .wdata (ld_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_pc_bad ? RESP : READ;
      READ:    if (r_cnt == c_last_cnt) w_next = RESP;
      RESP:    if (bus.rsp_ready) w_next = w_halt_word ? HALTED : IDLE;
      HALTED:  w_next = HALTED;
      default: w_next = IDLE;
    endcase
  end

  // Request latch, byte-serial word assembly and sticky halt flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= '0;
      r_cnt    <= 2'd0;
      r_instr  <= 32'd0;
      r_err    <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_pc    <= bus.req_pc[LD_AW-1:0];
            r_cnt   <= 2'd0;
            r_instr <= 32'd0;
            r_err   <= w_pc_bad;
          end
        end
        READ: begin
          r_instr[{r_cnt, 3'b000} +: 8] <= w_rdata;
          r_cnt                         <= r_cnt + 2'd1;
        end
        RESP: begin
          if (bus.rsp_ready && w_halt_word) r_halted <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_responder
// Purpose  : Directed self-checking bench for imem_responder with a response
//            scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_responder;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_en = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic        halted;

  imem_responder_if bus();

  imem_responder #(
    .DEPTH_BYTES (4096),
    .LD_AW       (12)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .halted  (halted),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
    logic        halt;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic load_word(input logic [11:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) load(a + 12'(i), w[8*i +: 8]);
  endtask

  // One fetch: hold = cycles of rsp_ready backpressure, busy_req keeps
  // req_valid high while busy, busy_ld pulses ld_en during READ.
  task automatic fetch(input logic [63:0] pc, input logic [31:0] instr, input logic err,
                       input logic halt, input int hold, input bit busy_req, input bit busy_ld);
    rsp_t        e;
    int          n;
    int          lat;
    logic [31:0] held;
    sb.push_back({instr, err, halt});
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_pc    = pc;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready_at_accept", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = busy_req;
    if (busy_ld) begin ld_en = 1'b1; ld_addr = pc[11:0]; ld_data = 8'h55; end
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      if (busy_req) chk("no_accept_in_read", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
      ld_en = 1'b0;
      lat++;
    end
    ld_en = 1'b0;
    chk("latency", 64'(lat), err ? 64'd1 : 64'd5);
    e = sb.pop_front();
    chk("rsp_instr", 64'(bus.rsp_instr), 64'(e.instr));
    chk("rsp_err",   64'(bus.rsp_err),   64'(e.err));
    chk("rsp_halt",  64'(bus.rsp_halt),  64'(e.halt));
    held = bus.rsp_instr;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("held_valid", 64'(bus.rsp_valid), 64'd1);
      chk("held_instr", 64'(bus.rsp_instr), 64'(held));
      if (busy_req) chk("no_accept_in_resp", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    chk("rsp_valid_drop", 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_pc    = '0;
    bus.rsp_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_instr", 64'(bus.rsp_instr), 64'd0);
    chk("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
    chk("rst_rsp_halt",  64'(bus.rsp_halt),  64'd0);
    chk("rst_halted",    64'(halted),        64'd0);
    rst_n = 1'b1;

    // Preload and basic fetch
    load_word(12'd0, 32'hF81F028B);
    fetch(64'd0, 32'hF81F028B, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Misaligned, then normal
    fetch(64'h2, 32'h0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    fetch(64'd0, 32'hF81F028B, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Range boundaries
    load_word(12'd4092, 32'h44332211);
    fetch(64'd4096, 32'h0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    fetch(64'h8000_0000_0000_0000, 32'h0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    fetch(64'd4092, 32'h44332211, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Backpressure with request held high while busy
    fetch(64'd0, 32'hF81F028B, 1'b0, 1'b0, 3, 1'b1, 1'b0);

    // Load has priority over a request in IDLE
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 12'd24; ld_data = 8'hEF;
    bus.req_valid = 1'b1; bus.req_pc = 64'd0;
    #1;
    chk("ld_blocks_req_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    ld_en = 1'b0; bus.req_valid = 1'b0;
    load(12'd25, 8'hBE);
    load(12'd26, 8'hAD);
    load(12'd27, 8'hDE);
    fetch(64'd24, 32'hDEADBEEF, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Load during READ is ignored
    fetch(64'd24, 32'hDEADBEEF, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    fetch(64'd24, 32'hDEADBEEF, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Reset during READ with cnt==2
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_pc = 64'd0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("midrst_rsp_instr", 64'(bus.rsp_instr), 64'd0);
    chk("midrst_req_ready", 64'(bus.req_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", 64'(bus.rsp_valid), 64'd0);
    end
    rst_n = 1'b1;
    fetch(64'd0, 32'hF81F028B, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // HALT
    load_word(12'd8, 32'hFFE00000);
    fetch(64'd8, 32'hFFE00000, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    chk("halted_set", 64'(halted), 64'd1);
    bus.req_valid = 1'b1; bus.req_pc = 64'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("halted_req_ready", 64'(bus.req_ready), 64'd0);
      chk("halted_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    end
    bus.req_valid = 1'b0;
    load_word(12'd40, 32'h12345678);
    chk("halted_sticky", 64'(halted), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("halted_cleared", 64'(halted), 64'd0);
    rst_n = 1'b1;
    fetch(64'd40, 32'h12345678, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
